// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: FSM state encoding, LC-3b word type
// and the wait-counter width.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } mau_state_e;

   localparam int CNT_W = 16;

endpackage

// File: rtl/mem_access_unit_byte_lane_sel.sv
// Byte-lane steering: extracts and zero-extends a load lane, replicates a store
// byte across all lanes and builds the byte-enable mask.
module byte_lane_sel #(
   parameter int WIDTH = 16,
   parameter int LANES = WIDTH / 8,
   parameter int LB    = $clog2(LANES)
) (
   input  logic             byte_op,
   input  logic [LB-1:0]    lane,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic [WIDTH-1:0] store_word,
   output logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] store_data,
   output logic [LANES-1:0] byte_enable
);

   logic [WIDTH-1:0] lane_data;

   always_comb begin
      lane_data      = '0;
      lane_data[7:0] = mem_rdata[{lane, 3'b000} +: 8];
      load_data      = byte_op ? lane_data : mem_rdata;
   end

   // A byte store puts the byte on every lane; the enable mask picks the real one.
   assign store_data  = byte_op ? {LANES{store_word[7:0]}} : store_word;
   assign byte_enable = byte_op ? (LANES'(1) << lane) : '1;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine between a simple request port and a
// memory with a mem_resp completion strobe; handles byte lanes and timeouts.
module mem_access_unit
   import lc3b_types::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic                  byte_op,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  ready,
   output logic                  done,
   output logic                  error,
   output logic [WIDTH-1:0]      rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [WIDTH/8-1:0]    mem_byte_enable,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_resp,
   output mau_state_e            state_dbg
);

   localparam int LANES = WIDTH / 8;
   localparam int LB    = $clog2(LANES);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   // Handshake: a request (req_read/req_write) is taken only on a cycle where
   // ready=1; the result is reported by a one-cycle done pulse, with error and
   // rdata valid at that pulse. Memory side: mem_read/mem_write stay high until
   // mem_resp is seen for one cycle, or the wait counter expires.

   mau_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] mar_q;
   logic [WIDTH-1:0]      mdr_q;
   logic [CNT_W-1:0]      wait_q;
   logic                  err_q;
   logic                  byte_q;
   logic                  misaligned;
   logic                  accept;
   logic [WIDTH-1:0]      load_data;

   assign misaligned = !byte_op && (addr[LB-1:0] != '0);
   assign accept     = req_read || req_write;

   byte_lane_sel #(.WIDTH(WIDTH)) u_lane (
      .byte_op     (byte_q),
      .lane        (mar_q[LB-1:0]),
      .mem_rdata   (mem_rdata),
      .store_word  (mdr_q),
      .load_data   (load_data),
      .store_data  (mem_wdata),
      .byte_enable (mem_byte_enable)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (misaligned)    state_d = ST_DONE;
               else if (req_read) state_d = ST_READ;
               else               state_d = ST_WRITE;
            end
         end
         ST_READ, ST_WRITE: begin
            if (mem_resp || wait_q == WAIT_LAST) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready       = (state_q == ST_IDLE);
      done        = (state_q == ST_DONE);
      error       = (state_q == ST_DONE) && err_q;
      mem_read    = (state_q == ST_READ);
      mem_write   = (state_q == ST_WRITE);
      mem_address = mar_q;
      rdata       = mdr_q;
      state_dbg   = state_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mar_q  <= '0;
         mdr_q  <= '0;
         wait_q <= '0;
         err_q  <= 1'b0;
         byte_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  mar_q  <= addr;
                  byte_q <= byte_op;
                  wait_q <= '0;
                  err_q  <= misaligned;
                  if (!req_read) mdr_q <= wdata;
               end
            end
            ST_READ, ST_WRITE: begin
               if (mem_resp) begin
                  if (state_q == ST_READ) mdr_q <= load_data;
               end else begin
                  wait_q <= wait_q + 1'b1;
                  if (wait_q == WAIT_LAST) err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (WIDTH=16, TIMEOUT=4) with hand-computed
// expectations for word/byte loads and stores, misalignment, timeout and reset.
module tb_mem_access_unit;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_read, req_write, byte_op;
   logic [15:0] addr, wdata;
   logic        ready, done, error;
   logic [15:0] rdata, mem_address;
   logic        mem_read, mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_resp;
   mau_state_e  state_dbg;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_read        (req_read),
      .req_write       (req_write),
      .byte_op         (byte_op),
      .addr            (addr),
      .wdata           (wdata),
      .ready           (ready),
      .done            (done),
      .error           (error),
      .rdata           (rdata),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .state_dbg       (state_dbg)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Presents a request for one cycle; returns at the negedge of cycle 1.
   task automatic issue(input logic rd, input logic wr, input logic bop,
                        input logic [15:0] a, input logic [15:0] wd);
      @(negedge clk);
      check_eq("ready_before_req", 32'(ready), 32'd1);
      req_read  = rd;
      req_write = wr;
      byte_op   = bop;
      addr      = a;
      wdata     = wd;
      @(negedge clk);
      req_read  = 1'b0;
      req_write = 1'b0;
   endtask

   // Walks cycles from cycle 1, raising mem_resp at resp_cyc (0 = never),
   // and checks the cycle at which done appears plus its error flag.
   task automatic run_wait(input int resp_cyc, input int exp_cyc, input logic exp_err,
                           input logic exp_rd, input logic exp_wr);
      int c;
      bit seen;
      c    = 1;
      seen = 1'b0;
      while (!seen && c <= 20) begin
         if (done) begin
            seen     = 1'b1;
            mem_resp = 1'b0;
            check_eq("done_cycle", 32'(c), 32'(exp_cyc));
            check_eq("done_error", 32'(error), 32'(exp_err));
            check_eq("done_no_mem_write", 32'(mem_write), 32'd0);
            check_eq("done_no_mem_read", 32'(mem_read), 32'd0);
         end else begin
            check_eq("busy_mem_read", 32'(mem_read), 32'(exp_rd));
            check_eq("busy_mem_write", 32'(mem_write), 32'(exp_wr));
            check_eq("busy_not_ready", 32'(ready), 32'd0);
            mem_resp = (c == resp_cyc);
            @(negedge clk);
            c++;
         end
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      mem_resp = 1'b0;
      @(negedge clk);
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("back_to_idle", 32'(ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      req_read  = 1'b0;
      req_write = 1'b0;
      byte_op   = 1'b0;
      addr      = '0;
      wdata     = '0;
      mem_rdata = '0;
      mem_resp  = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_error", 32'(error), 32'd0);
      check_eq("rst_mem_read", 32'(mem_read), 32'd0);
      check_eq("rst_mem_write", 32'(mem_write), 32'd0);
      check_eq("rst_rdata", 32'(rdata), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;

      // Word read, response at cycle 3 -> done at cycle 4.
      mem_rdata = 16'hBEEF;
      issue(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000);
      check_eq("wr_rd_addr", 32'(mem_address), 32'h1000);
      check_eq("wr_rd_be", 32'(mem_byte_enable), 32'b11);
      run_wait(3, 4, 1'b0, 1'b1, 1'b0);
      check_eq("word_rd_rdata", 32'(rdata), 32'hBEEF);

      // Byte read, upper lane.
      issue(1'b1, 1'b0, 1'b1, 16'h1001, 16'h0000);
      check_eq("byte_rd_hi_be", 32'(mem_byte_enable), 32'b10);
      run_wait(1, 2, 1'b0, 1'b1, 1'b0);
      check_eq("byte_rd_hi_rdata", 32'(rdata), 32'h00BE);

      // Byte read, lower lane.
      issue(1'b1, 1'b0, 1'b1, 16'h1000, 16'h0000);
      check_eq("byte_rd_lo_be", 32'(mem_byte_enable), 32'b01);
      run_wait(2, 3, 1'b0, 1'b1, 1'b0);
      check_eq("byte_rd_lo_rdata", 32'(rdata), 32'h00EF);

      // Timeout: no response, TIMEOUT=4 -> done at cycle 5, rdata unchanged.
      mem_rdata = 16'h5555;
      issue(1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000);
      run_wait(0, 5, 1'b1, 1'b1, 1'b0);
      check_eq("timeout_rdata", 32'(rdata), 32'h00EF);

      // Byte write, replicated store byte.
      issue(1'b0, 1'b1, 1'b1, 16'h2000, 16'h1234);
      check_eq("byte_wr_addr", 32'(mem_address), 32'h2000);
      check_eq("byte_wr_wdata", 32'(mem_wdata), 32'h3434);
      check_eq("byte_wr_be", 32'(mem_byte_enable), 32'b01);
      run_wait(2, 3, 1'b0, 1'b0, 1'b1);

      // Aligned word write.
      issue(1'b0, 1'b1, 1'b0, 16'h2002, 16'hA5C3);
      check_eq("word_wr_wdata", 32'(mem_wdata), 32'hA5C3);
      check_eq("word_wr_be", 32'(mem_byte_enable), 32'b11);
      run_wait(1, 2, 1'b0, 1'b0, 1'b1);

      // Misaligned word write and read finish at cycle 1 with error.
      issue(1'b0, 1'b1, 1'b0, 16'h2003, 16'hFFFF);
      run_wait(0, 1, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 16'h1001, 16'h0000);
      run_wait(0, 1, 1'b1, 1'b0, 1'b0);

      // Simultaneous read and write: read wins.
      mem_rdata = 16'h1357;
      issue(1'b1, 1'b1, 1'b0, 16'h4000, 16'h9999);
      run_wait(1, 2, 1'b0, 1'b1, 1'b0);
      check_eq("rd_wins_rdata", 32'(rdata), 32'h1357);

      // mem_resp while idle is ignored.
      mem_resp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("idle_resp_no_done", 32'(done), 32'd0);
         check_eq("idle_resp_ready", 32'(ready), 32'd1);
      end
      mem_resp = 1'b0;

      // Reset in the middle of a read.
      mem_rdata = 16'hCAFE;
      issue(1'b1, 1'b0, 1'b0, 16'h5000, 16'h0000);
      check_eq("pre_rst_mem_read", 32'(mem_read), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_mem_read", 32'(mem_read), 32'd0);
      check_eq("mid_rst_ready", 32'(ready), 32'd1);
      @(negedge clk);
      reset    = 1'b0;
      mem_resp = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("late_resp_no_done", 32'(done), 32'd0);
         check_eq("late_resp_rdata", 32'(rdata), 32'd0);
      end
      mem_resp = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
